// File: rtl/psram_qspi_ctrl.sv
// psram_qspi_ctrl: APB slave issuing one serial/quad SPI PSRAM command per access
// Ports: pclk/prst clock and sync reset; APB slave paddr/pwdata/pstrb/psel/penable/pwrite
// in, prdata/pready/pslverr out; PSRAM side cs_n, sck (mode 0), dq_o/dq_oe out, dq_i in.
module psram_qspi_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BYTES = 3,
  parameter int CLK_DIV = 2,
  parameter int QUAD = 0,
  parameter int READ_WAIT = 6,
  parameter int CS_GAP = 2
) (
  input  logic pclk,
  input  logic prst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic pready,
  output logic pslverr,
  output logic cs_n,
  output logic sck,
  output logic [3:0] dq_o,
  output logic [3:0] dq_oe,
  input  logic [3:0] dq_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = DATA_WIDTH > 32 ? DATA_WIDTH : 32;
  localparam int DVW = $clog2(CLK_DIV + 1);
  localparam logic [DVW-1:0] DIV_MAX = DVW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, DONE, GAP} state_t;
  state_t state, nst, st_nx;
  logic [TW-1:0] tx, ld_tx, tx_nx;
  logic [15:0] cnt, ld_cnt, gcnt;
  logic [DVW-1:0] div;
  logic [DATA_WIDTH-1:0] wdata_r, rx, seq, rd_word;
  logic [31:0] addr_r;
  logic [3:0] k_r, n_r, in_k, in_n, dq_o_nx, dq_oe_nx;
  logic [SW-1:0] sh;
  logic [7:0] cmd;
  logic wr_r, drop, in_ok, quad_sh, quad_ph, drv;
  function automatic logic [DATA_WIDTH-1:0] byte_rev(input logic [DATA_WIDTH-1:0] v);
    for (int i = 0; i < SW; i++) byte_rev[8*i +: 8] = v[DATA_WIDTH-8-8*i +: 8];
  endfunction
  // tx is left-aligned: the next bit (serial) or nibble (quad) to drive is always at the top.
  // Read bytes shift into rx in arrival order; byte-reversing then shifting drops them into lanes k..k+n-1.
  always_comb begin
    in_k = '0;
    for (int i = SW - 1; i >= 0; i--) if (pstrb[i]) in_k = 4'(i);
    in_n = 4'($countones(pstrb));
    sh = pstrb >> in_k;
    in_ok = pstrb != '0 && (sh & (sh + SW'(1))) == '0;
    cmd = QUAD != 0 ? (pwrite ? 8'h38 : 8'hEB) : (pwrite ? 8'h02 : 8'h03);
    seq = byte_rev(wdata_r >> {k_r, 3'b0});
    rd_word = (byte_rev(rx) >> {4'(SW) - n_r, 3'b0}) << {k_r, 3'b0};
    nst = state == CMD ? ADDR : state == ADDR ? (QUAD != 0 && !wr_r && READ_WAIT > 0 ? WAIT : DATA) : state == WAIT ? DATA : DONE;
    ld_tx = nst == ADDR ? TW'(addr_r) << (TW - 8 * ADDR_BYTES) : nst == DATA ? TW'(seq) << (TW - DATA_WIDTH) : '0;
    ld_cnt = nst == ADDR ? 16'(QUAD != 0 ? 2 * ADDR_BYTES : 8 * ADDR_BYTES) : nst == WAIT ? 16'(READ_WAIT) : 16'(n_r) << (QUAD != 0 ? 1 : 3);
    quad_sh = QUAD != 0 && state != CMD;
    tx_nx = cnt == 16'd1 ? ld_tx : (quad_sh ? tx << 4 : tx << 1);
    st_nx = cnt == 16'd1 ? nst : state;
    quad_ph = QUAD != 0 && st_nx != CMD;
    drv = st_nx == CMD || st_nx == ADDR || (st_nx == DATA && wr_r);
    dq_oe_nx = !drv ? 4'h0 : quad_ph ? 4'hF : 4'h1;
    dq_o_nx = !drv ? 4'h0 : quad_ph ? tx_nx[TW-1 -: 4] : {3'b0, tx_nx[TW-1]};
  end
  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= IDLE;
      cs_n <= 1'b1;
      sck <= 1'b0;
      dq_o <= '0;
      dq_oe <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      div <= '0;
      cnt <= '0;
      gcnt <= '0;
      tx <= '0;
      rx <= '0;
      wdata_r <= '0;
      addr_r <= '0;
      k_r <= '0;
      n_r <= '0;
      wr_r <= 1'b0;
      drop <= 1'b0;
    end else begin
      case (state)
        IDLE: if (psel && penable) begin
          wr_r <= pwrite;
          wdata_r <= pwdata;
          k_r <= in_k;
          n_r <= in_n;
          addr_r <= 32'((paddr & ~ADDR_WIDTH'(SW - 1)) + ADDR_WIDTH'(in_k));
          drop <= 1'b0;
          rx <= '0;
          div <= '0;
          cnt <= 16'd8;
          tx <= TW'(cmd) << (TW - 8);
          if (in_ok) begin
            state <= CMD;
            cs_n <= 1'b0;
            dq_o <= {3'b0, cmd[7]};
            dq_oe <= 4'h1;
          end else begin
            state <= DONE;
            pready <= 1'b1;
            pslverr <= 1'b1;
          end
        end
        DONE: begin
          pready <= 1'b0;
          pslverr <= 1'b0;
          gcnt <= 16'(CS_GAP - 1);
          state <= CS_GAP > 1 ? GAP : IDLE;
        end
        GAP: begin
          gcnt <= gcnt - 16'd1;
          if (gcnt == 16'd1) state <= IDLE;
        end
        default: begin
          if (!psel) drop <= 1'b1;
          if (div != DIV_MAX) div <= div + DVW'(1);
          else begin
            div <= '0;
            if (!sck) begin
              sck <= 1'b1;
              if (state == DATA && !wr_r) rx <= QUAD != 0 ? {rx[DATA_WIDTH-5:0], dq_i} : {rx[DATA_WIDTH-2:0], dq_i[1]};
            end else begin
              sck <= 1'b0;
              cnt <= cnt == 16'd1 ? ld_cnt : cnt - 16'd1;
              tx <= tx_nx;
              state <= st_nx;
              dq_o <= dq_o_nx;
              dq_oe <= dq_oe_nx;
              if (st_nx == DONE) begin
                cs_n <= 1'b1;
                pready <= psel && !drop;
                pslverr <= 1'b0;
                if (!wr_r && psel && !drop) prdata <= rd_word;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// tb_psram_qspi_ctrl: scoreboard bench for serial and quad psram_qspi_ctrl instances
module tb_psram_qspi_ctrl;
  logic pclk = 0, prst = 1;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0] pstrb = '0;
  logic s_psel = 0, q_psel = 0, penable = 0, pwrite = 0;
  logic [31:0] s_prdata, q_prdata;
  logic s_pready, s_pslverr, s_csn, s_sck, q_pready, q_pslverr, q_csn, q_sck;
  logic [3:0] s_dqo, s_dqoe, q_dqo, q_dqoe;
  logic [3:0] s_dqi = '0, q_dqi = '0;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct { int t0; int lat; logic err; logic [31:0] rd; } apb_e;
  typedef struct { logic [7:0] cmd; logic [23:0] addr; int nsck; logic [63:0] data; } bus_e;
  apb_e s_q[$], q_q[$];
  bus_e bus_q[$];
  apb_e sm, qm;
  bus_e bm;
  logic [7:0] mem [bit [23:0]];
  int s_n = 0, s_j, s_falls = 0, q_n = 0, q_dummy, q_bad_oe;
  logic [7:0] s_cmd, s_b, q_cmd;
  logic [23:0] s_addr, q_addr;
  logic [63:0] s_pk;
  logic [7:0] s_bytes[$];
  bit s_skip = 0;

  psram_qspi_ctrl u_ser (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(s_psel), .penable(penable), .pwrite(pwrite), .prdata(s_prdata),
    .pready(s_pready), .pslverr(s_pslverr), .cs_n(s_csn), .sck(s_sck),
    .dq_o(s_dqo), .dq_oe(s_dqoe), .dq_i(s_dqi));

  psram_qspi_ctrl #(.QUAD(1), .READ_WAIT(6)) u_quad (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .psel(q_psel), .penable(penable), .pwrite(pwrite), .prdata(q_prdata),
    .pready(q_pready), .pslverr(q_pslverr), .cs_n(q_csn), .sck(q_sck),
    .dq_o(q_dqo), .dq_oe(q_dqoe), .dq_i(q_dqi));

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // serial PSRAM model
  always @(negedge s_csn) begin
    s_n = 0; s_cmd = '0; s_addr = '0; s_b = '0; s_bytes.delete(); s_falls++;
  end
  always @(posedge s_sck) begin
    if (s_n < 8) s_cmd = {s_cmd[6:0], s_dqo[0]};
    else if (s_n < 32) s_addr = {s_addr[22:0], s_dqo[0]};
    else if (s_cmd == 8'h02) begin
      s_b = {s_b[6:0], s_dqo[0]};
      if (s_n % 8 == 7) s_bytes.push_back(s_b);
    end
    s_n++;
  end
  always @(negedge s_sck) if (s_n >= 32 && s_cmd == 8'h03) begin
    s_j = s_n - 32;
    s_b = mem.exists(s_addr + 24'(s_j / 8)) ? mem[s_addr + 24'(s_j / 8)] : 8'h00;
    s_dqi[1] = s_b[7 - s_j % 8];
  end
  always @(posedge s_csn) if (s_n > 0) begin
    if (s_skip) s_skip = 0;
    else begin
      if (s_cmd == 8'h02) foreach (s_bytes[i]) mem[s_addr + 24'(i)] = s_bytes[i];
      s_pk = '0;
      foreach (s_bytes[i]) s_pk = {s_pk[55:0], s_bytes[i]};
      if (bus_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL s_transfer unexpected: cmd %h addr %h", s_cmd, s_addr);
      end else begin
        bm = bus_q.pop_front();
        chk("s_cmd", s_cmd, bm.cmd);
        chk("s_addr", s_addr, bm.addr);
        chk("s_nsck", s_n, bm.nsck);
        chk("s_wdata", s_pk, bm.data);
      end
    end
  end

  // quad PSRAM model: returns byte 5Ah
  always @(negedge q_csn) begin
    q_n = 0; q_cmd = '0; q_addr = '0; q_dummy = 0; q_bad_oe = 0;
  end
  always @(posedge q_sck) begin
    if (q_n < 8) q_cmd = {q_cmd[6:0], q_dqo[0]};
    else if (q_n < 14) begin
      q_addr = {q_addr[19:0], q_dqo};
      if (q_dqoe !== 4'hF) q_bad_oe++;
    end else if (q_n < 20) begin
      if (q_dqoe === 4'h0) q_dummy++;
    end
    q_n++;
  end
  always @(negedge q_sck) if (q_n >= 20) q_dqi = q_n == 20 ? 4'h5 : 4'hA;
  always @(posedge q_csn) if (q_n > 0) begin
    chk("q_cmd", q_cmd, 8'hEB);
    chk("q_addr", q_addr, 24'h000010);
    chk("q_nsck", q_n, 22);
    chk("q_dummy", q_dummy, 6);
    chk("q_addr_oe_bad", q_bad_oe, 0);
  end

  // APB response monitor
  always @(negedge pclk) begin
    if (s_pready === 1'b1) begin
      if (s_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL s_pready unexpected at cycle %0d", cyc);
      end else begin
        sm = s_q.pop_front();
        chk("s_latency", 64'(cyc - sm.t0), 64'(sm.lat));
        chk("s_pslverr", s_pslverr, sm.err);
        chk("s_prdata", s_prdata, sm.rd);
      end
    end
    if (q_pready === 1'b1) begin
      if (q_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL q_pready unexpected at cycle %0d", cyc);
      end else begin
        qm = q_q.pop_front();
        chk("q_latency", 64'(cyc - qm.t0), 64'(qm.lat));
        chk("q_pslverr", q_pslverr, qm.err);
        chk("q_prdata", q_prdata, qm.rd);
      end
    end
  end

  task automatic apb(input bit quad, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit w, input int lat, input bit err, input logic [31:0] rd);
    int n;
    apb_e e;
    @(posedge pclk); #1;
    paddr = a; pwdata = d; pstrb = s; pwrite = w;
    if (quad) q_psel = 1; else s_psel = 1;
    @(posedge pclk); #1;
    penable = 1;
    e.t0 = cyc + 1; e.lat = lat; e.err = err; e.rd = rd;
    if (quad) q_q.push_back(e); else s_q.push_back(e);
    n = 0;
    do begin @(negedge pclk); n++; end while (!(quad ? q_pready : s_pready) && n < 3000);
    if (n >= 3000) begin
      checks++; fails++;
      $display("FAIL apb_timeout addr %h: no pready", a);
    end
    @(posedge pclk); #1;
    s_psel = 0; q_psel = 0; penable = 0;
  endtask

  task automatic expect_bus(input logic [7:0] c, input logic [23:0] a, input int ns, input logic [63:0] d);
    bus_e b;
    b.cmd = c; b.addr = a; b.nsck = ns; b.data = d;
    bus_q.push_back(b);
  endtask

  initial begin
    int n, f0;
    repeat (3) @(posedge pclk);
    #1 prst = 0;
    @(negedge pclk);
    chk("rst_cs_n", s_csn, 1'b1);
    chk("rst_sck", s_sck, 1'b0);
    chk("rst_dq_oe", s_dqoe, 4'h0);
    chk("rst_pready", s_pready, 1'b0);
    chk("rst_prdata", s_prdata, 32'h0);

    expect_bus(8'h02, 24'h000100, 64, 64'h11223344);
    apb(0, 32'h100, 32'h44332211, 4'hF, 1, 256, 0, 32'h0);
    expect_bus(8'h03, 24'h000100, 64, 64'h0);
    apb(0, 32'h100, 32'h0, 4'hF, 0, 256, 0, 32'h44332211);
    expect_bus(8'h02, 24'h000202, 48, 64'hAABB);
    apb(0, 32'h200, 32'hBBAA0000, 4'hC, 1, 192, 0, 32'h44332211);
    expect_bus(8'h03, 24'h000202, 48, 64'h0);
    apb(0, 32'h200, 32'h0, 4'hC, 0, 192, 0, 32'hBBAA0000);

    f0 = s_falls;
    apb(0, 32'h400, 32'h12345678, 4'h5, 1, 0, 1, 32'hBBAA0000);
    apb(0, 32'h400, 32'h12345678, 4'h0, 0, 0, 1, 32'hBBAA0000);
    chk("err_no_cs", s_falls - f0, 0);

    apb(1, 32'h10, 32'h0, 4'h1, 0, 88, 0, 32'h0000005A);

    @(posedge pclk); #1;
    paddr = 32'h300; pwdata = 32'hDEADBEEF; pstrb = 4'hF; pwrite = 1; s_psel = 1;
    @(posedge pclk); #1;
    penable = 1;
    n = 0;
    while ((s_csn !== 1'b0 || s_n < 40) && n < 1000) begin @(negedge pclk); n++; end
    if (n >= 1000) begin
      checks++; fails++;
      $display("FAIL abort_wait: data phase not reached");
    end
    s_skip = 1;
    @(posedge pclk); #1;
    prst = 1; s_psel = 0; penable = 0;
    @(posedge pclk); #1;
    prst = 0;
    @(negedge pclk);
    chk("abort_cs_n", s_csn, 1'b1);
    chk("abort_sck", s_sck, 1'b0);
    chk("abort_dq_o", s_dqo, 4'h0);
    chk("abort_dq_oe", s_dqoe, 4'h0);
    chk("abort_pready", s_pready, 1'b0);
    chk("abort_pslverr", s_pslverr, 1'b0);
    chk("abort_prdata", s_prdata, 32'h0);

    expect_bus(8'h03, 24'h000100, 64, 64'h0);
    apb(0, 32'h100, 32'h0, 4'hF, 0, 256, 0, 32'h44332211);

    repeat (10) @(posedge pclk);
    chk("s_q_drained", s_q.size(), 0);
    chk("q_q_drained", q_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
